pbit_field_acc: RTL and testbench

- Computes the local field of one p-bit from the binary states of its neighbours and drives that p-bit's input_val/bit_shift pins.
- Weighted sum: bias + Σ w_j·s_j, where spin bit 1 = +1 and spin bit 0 = −1.
- Operates serially, one neighbour per cycle, under a start/done handshake.
- Sits between the neighbour spin bus and a p_bit instance, closing the spin→field→spin loop.

---
 rtl/pbit_pkg.sv | 20 ++
 rtl/pbit_field_acc_if.sv | 38 +++
 rtl/pbit_sat.sv | 25 ++
 rtl/pbit_field_acc.sv | 143 ++++++++++++++
 tb/tb_pbit_field_acc.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pbit_pkg.sv
// Shared types and defaults for the p-bit local-field accumulator.
// Holds the FSM state encoding, default widths and the spin-to-sign mapping.
package pbit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } state_e;

  localparam int DEF_W_WIDTH   = 4;
  localparam int DEF_ACC_WIDTH = 8;
  localparam int DEF_OUT_WIDTH = 4;

  // Spin bit 1 is +1, spin bit 0 is -1.
  function automatic logic signed [1:0] spin_to_sign(input logic s);
    return s ? 2'sd1 : -2'sd1;
  endfunction

endpackage

// File: rtl/pbit_field_acc_if.sv
// Handshake and data bus between the neighbour spin side and the p-bit input side.
// Carries sat_flag only when PBIT_FIELD_SAT_FLAG_EN is defined.
interface pbit_field_acc_if #(
  parameter int N_NEIGH   = 4,
  parameter int W_WIDTH   = 4,
  parameter int OUT_WIDTH = 4
);
  logic                         start;
  logic [N_NEIGH-1:0]           spins;
  logic [N_NEIGH*W_WIDTH-1:0]   weights;
  logic [W_WIDTH-1:0]           bias;
  logic [1:0]                   beta_in;
  logic                         busy;
  logic                         done;
  logic [OUT_WIDTH-1:0]         input_val;
  logic [1:0]                   bit_shift;
`ifdef PBIT_FIELD_SAT_FLAG_EN
  logic                         sat_flag;

  modport master (
    output start, spins, weights, bias, beta_in,
    input  busy, done, input_val, bit_shift, sat_flag
  );
  modport slave (
    input  start, spins, weights, bias, beta_in,
    output busy, done, input_val, bit_shift, sat_flag
  );
`else
  modport master (
    output start, spins, weights, bias, beta_in,
    input  busy, done, input_val, bit_shift
  );
  modport slave (
    input  start, spins, weights, bias, beta_in,
    output busy, done, input_val, bit_shift
  );
`endif
endinterface

// File: rtl/pbit_sat.sv
// Combinational signed clamp from IN_W to OUT_W bits with a clipped indicator.
// Requires IN_W >= OUT_W.
module pbit_sat #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clipped
);
  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout    = din[OUT_W-1:0];
    clipped = 1'b0;
    if (din > MAXV) begin
      dout    = MAXV[OUT_W-1:0];
      clipped = 1'b1;
    end else if (din < MINV) begin
      dout    = MINV[OUT_W-1:0];
      clipped = 1'b1;
    end
  end
endmodule

// File: rtl/pbit_field_acc.sv
// Serial local-field accumulator: bias + sum(+/-w_j), one neighbour per cycle, then clamp.
// Optional sat_flag output enabled by defining PBIT_FIELD_SAT_FLAG_EN.
module pbit_field_acc
  import pbit_pkg::*;
#(
  parameter int N_NEIGH   = 4,
  parameter int W_WIDTH   = DEF_W_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  pbit_field_acc_if.slave bus
);
  localparam int IDX_W = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEIGH - 1);

  state_e                       state_q, state_d;
  logic [ACC_WIDTH-1:0]         acc_q, acc_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [N_NEIGH-1:0]           spin_snap_q, spin_snap_d;
  logic [N_NEIGH*W_WIDTH-1:0]   w_snap_q, w_snap_d;
  logic [1:0]                   beta_snap_q, beta_snap_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic [OUT_WIDTH-1:0]         val_q, val_d;
  logic [1:0]                   shift_q, shift_d;

  logic [N_NEIGH-1:0][ACC_WIDTH-1:0] lane_term;
  logic [ACC_WIDTH-1:0]         bias_ext;
  logic signed [OUT_WIDTH-1:0]  sat_val;
  logic                         sat_clip;

  // Each lane presents its signed contribution; the FSM picks one per cycle.
  for (genvar j = 0; j < N_NEIGH; j++) begin : g_lane
    logic [W_WIDTH-1:0]   w_raw;
    logic [ACC_WIDTH-1:0] w_ext;
    assign w_raw        = w_snap_q[j*W_WIDTH +: W_WIDTH];
    assign w_ext        = {{(ACC_WIDTH-W_WIDTH){w_raw[W_WIDTH-1]}}, w_raw};
    assign lane_term[j] = (spin_to_sign(spin_snap_q[j]) == 2'sd1) ? w_ext : (~w_ext + 1'b1);
  end

  assign bias_ext = {{(ACC_WIDTH-W_WIDTH){bus.bias[W_WIDTH-1]}}, bus.bias};

  pbit_sat #(.IN_W(ACC_WIDTH), .OUT_W(OUT_WIDTH)) u_sat (
    .din     (acc_q),
    .dout    (sat_val),
    .clipped (sat_clip)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    spin_snap_d = spin_snap_q;
    w_snap_d    = w_snap_q;
    beta_snap_d = beta_snap_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    val_d       = val_q;
    shift_d     = shift_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          spin_snap_d = bus.spins;
          w_snap_d    = bus.weights;
          beta_snap_d = bus.beta_in;
          acc_d       = bias_ext;
          idx_d       = '0;
          busy_d      = 1'b1;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + lane_term[idx_q];
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = SAT;
        end
      end
      SAT: begin
        val_d   = sat_val;
        shift_d = beta_snap_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      spin_snap_q <= '0;
      w_snap_q    <= '0;
      beta_snap_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      val_q       <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      spin_snap_q <= spin_snap_d;
      w_snap_q    <= w_snap_d;
      beta_snap_q <= beta_snap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      val_q       <= val_d;
      shift_q     <= shift_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.input_val = val_q;
  assign bus.bit_shift = shift_q;

`ifdef PBIT_FIELD_SAT_FLAG_EN
  logic sat_flag_q, sat_flag_d;

  always_comb begin
    sat_flag_d = sat_flag_q;
    if (state_q == SAT) sat_flag_d = sat_clip;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sat_flag_q <= 1'b0;
    else        sat_flag_q <= sat_flag_d;
  end

  assign bus.sat_flag = sat_flag_q;
`else
  logic sat_clip_unused;
  assign sat_clip_unused = sat_clip;
`endif

endmodule

// File: tb/tb_pbit_field_acc.sv
// Directed plus randomized checks of pbit_field_acc against an arithmetic field model.
module tb_pbit_field_acc;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pbit_field_acc_if #(.N_NEIGH(N), .W_WIDTH(W), .OUT_WIDTH(OW)) bus ();

  pbit_field_acc #(.N_NEIGH(N), .W_WIDTH(W), .ACC_WIDTH(8), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic int model_sum(input logic [N-1:0] sp, input logic [N*W-1:0] wt,
                                   input logic [W-1:0] bs);
    int s;
    int w;
    s = int'($signed(bs));
    for (int j = 0; j < N; j++) begin
      w = int'($signed(wt[j*W +: W]));
      s = sp[j] ? s + w : s - w;
    end
    return s;
  endfunction

  function automatic int clamp_out(input int s);
    if (s > 7)  return 7;
    if (s < -8) return -8;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [N-1:0] sp, input logic [N*W-1:0] wt,
                        input logic [W-1:0] bs, input logic [1:0] bt);
    int e_sum;
    int e_val;
    int lat;
    logic [OW-1:0] held;
    e_sum = model_sum(sp, wt, bs);
    e_val = clamp_out(e_sum);
    @(negedge clk);
    bus.spins = sp; bus.weights = wt; bus.bias = bs; bus.beta_in = bt; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_on", 32'(bus.busy), 32'd1);
    held = bus.input_val;
    lat  = 0;
    while (lat < 12) begin
      // scramble live inputs: only the snapshot may matter
      bus.spins = 4'($urandom); bus.bias = 4'($urandom);
      bus.weights = 16'($urandom); bus.beta_in = 2'($urandom);
      @(posedge clk); #1;
      lat++;
      if (bus.done === 1'b1) break;
      chk("val_hold", 32'(bus.input_val), 32'(held));
    end
    chk("latency", 32'(lat), 32'd5);
    chk("input_val", 32'(bus.input_val), 32'(e_val & 15));
    chk("bit_shift", 32'(bus.bit_shift), 32'(bt));
    chk("busy_off", 32'(bus.busy), 32'd0);
`ifdef PBIT_FIELD_SAT_FLAG_EN
    chk("sat_flag", 32'(bus.sat_flag), (e_sum != e_val) ? 32'd1 : 32'd0);
`endif
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n_done;
    int last_done;
    int e_val;
    logic [OW-1:0] got_val;
    logic [15:0] wa;
    reset = 1'b0;
    bus.start = 1'b0; bus.spins = '0; bus.weights = '0; bus.bias = '0; bus.beta_in = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_val", 32'(bus.input_val), 32'd0);
    chk("rst_shift", 32'(bus.bit_shift), 32'd0);
    @(negedge clk); reset = 1'b1;

    // w0=1, w1=2, w2=3, w3=-4
    wa = {4'hC, 4'h3, 4'h2, 4'h1};
    run_op(4'b1111, wa, 4'h0, 2'b01);
    run_op(4'b0000, wa, 4'h0, 2'b10);
    run_op(4'b0101, wa, 4'h0, 2'b11);
    run_op(4'b1111, 16'h7777, 4'h7, 2'b00);
    run_op(4'b0000, 16'h7777, 4'h8, 2'b01);
    run_op(4'b0000, 16'h8888, 4'h3, 2'b10);
    run_op(4'b0000, 16'h8888, 4'h8, 2'b11);

    // second start during ACCUM must be ignored
    e_val = clamp_out(model_sum(4'b0011, wa, 4'h1));
    @(negedge clk);
    bus.spins = 4'b0011; bus.weights = wa; bus.bias = 4'h1; bus.beta_in = 2'b10; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_done = 0; got_val = '0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 2) begin
        bus.spins = 4'b1100; bus.weights = 16'h7777; bus.bias = 4'h7; bus.start = 1'b1;
      end
      if (i == 3) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        n_done++;
        got_val = bus.input_val;
      end
    end
    chk("ignore_cnt", 32'(n_done), 32'd1);
    chk("ignore_val", 32'(got_val), 32'(e_val & 15));

    // start held high: one update every 6 edges
    e_val = clamp_out(model_sum(4'b1010, wa, 4'hE));
    @(negedge clk);
    bus.spins = 4'b1010; bus.weights = wa; bus.bias = 4'hE; bus.beta_in = 2'b01; bus.start = 1'b1;
    n_done = 0; last_done = 0;
    for (int e = 1; e <= 26; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        if (n_done == 0) chk("b2b_first", 32'(e), 32'd6);
        else             chk("b2b_period", 32'(e - last_done), 32'd6);
        chk("b2b_val", 32'(bus.input_val), 32'(e_val & 15));
        n_done++;
        last_done = e;
      end
    end
    chk("b2b_cnt", 32'(n_done), 32'd4);
    @(negedge clk); bus.start = 1'b0;
    repeat (8) @(posedge clk);

    // reset two edges after start
    run_op(4'b1111, wa, 4'h1, 2'b11);
    @(negedge clk);
    bus.spins = 4'b1111; bus.weights = 16'h7777; bus.bias = 4'h0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_val", 32'(bus.input_val), 32'd0);
    chk("mid_rst_shift", 32'(bus.bit_shift), 32'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) n_done++;
    end
    chk("mid_rst_nodone", 32'(n_done), 32'd0);
    @(negedge clk); reset = 1'b1;
    run_op(4'b0101, wa, 4'hF, 2'b10);

    for (int r = 0; r < 30; r++)
      run_op(4'($urandom), 16'($urandom), 4'($urandom), 2'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
